// File: rtl/uart_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_reader
// Description : UART transmit engine. Pops one byte at a time from the read
//               side of a synchronous FIFO (registered read data, valid one
//               cycle after the read strobe) and serialises it as a frame:
//               start bit, DATA_WIDTH data bits LSB first, optional parity
//               bit, then one or two stop bits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   i_tx_en       in   enables fetching of new frames (sampled in IDLE only)
//   i_fifo_empty  in   FIFO empty flag (sampled in IDLE only)
//   i_fifo_rdata  in   FIFO registered read data (captured in LOAD)
//   o_fifo_ren    out  single-cycle FIFO read strobe, one per frame
//   o_txd         out  serial TX line, idle high
//   o_busy        out  high whenever the engine is not idle
//   o_done        out  one-cycle pulse on the cycle after the stop period
// ============================================================================
module uart_tx_fifo_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_tx_en,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_fifo_ren,
  output logic                  o_txd,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

  localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  c_last_data = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  c_last_stop = BIT_W'(STOP_BITS - 1);
  localparam logic              c_parity_en  = (PARITY_EN != 0);
  localparam logic              c_parity_odd = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [BAUD_W-1:0]     r_baud;
  logic [BAUD_W-1:0]     w_baud_next;
  logic [BIT_W-1:0]      r_bit;
  logic [BIT_W-1:0]      w_bit_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  r_parity;
  logic                  w_parity_next;
  logic                  w_baud_last;
  logic                  w_txd_next;
  logic                  r_txd;
  logic                  r_fifo_ren;
  logic                  r_busy;
  logic                  r_done;

  assign w_baud_last = (r_baud == c_baud_last);

  // Next-state, counter and datapath logic.
  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = '0;
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;

    // The baud counter only runs while a bit is on the line; it wraps on
    // every bit boundary and sits at zero elsewhere, so START always begins
    // from a cleared count.
    if ((r_state == ST_START) || (r_state == ST_DATA) ||
        (r_state == ST_PARITY) || (r_state == ST_STOP)) begin
      w_baud_next = w_baud_last ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        w_bit_next = '0;
        if (i_tx_en && !i_fifo_empty) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        // Registered FIFO data is valid in this cycle only.
        w_shift_next  = i_fifo_rdata;
        w_parity_next = (^i_fifo_rdata) ^ c_parity_odd;
        w_state_next  = ST_START;
      end
      ST_START: begin
        if (w_baud_last) begin
          w_bit_next   = '0;
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_baud_last) begin
          if (r_bit == c_last_data) begin
            w_bit_next   = '0;
            w_state_next = c_parity_en ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_next   = r_bit + 1'b1;
            w_shift_next = r_shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (w_baud_last) begin
          w_bit_next   = '0;
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        // The bit counter is reused to count stop-bit periods.
        if (w_baud_last) begin
          if (r_bit == c_last_stop) begin
            w_bit_next   = '0;
            w_state_next = ST_IDLE;
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Line level for the cycle after the edge, derived from the state being
  // entered so that o_txd can be a plain register.
  always_comb begin
    w_txd_next = 1'b1;
    case (w_state_next)
      ST_START:  w_txd_next = 1'b0;
      ST_DATA:   w_txd_next = w_shift_next[0];
      ST_PARITY: w_txd_next = w_parity_next;
      default:   w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_txd      <= 1'b1;
      r_fifo_ren <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud     <= w_baud_next;
      r_bit      <= w_bit_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_txd      <= w_txd_next;
      r_fifo_ren <= (w_state_next == ST_FETCH);
      r_busy     <= (w_state_next != ST_IDLE);
      r_done     <= (r_state == ST_STOP) && (w_state_next == ST_IDLE);
    end
  end

  assign o_txd      = r_txd;
  assign o_fifo_ren = r_fifo_ren;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
`default_nettype wire
